// File: rtl/ysyx_22050854_multiplier_v2.sv
// Iterative radix-4 Booth multiplier, one digit per cycle,
// with early termination and optional 32-bit word mode.
module ysyx_22050854_multiplier_v2 #(
  parameter int XLEN    = 64,
  parameter bit MULW_EN = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            mul_valid,
  input  logic            mulw,
  input  logic [1:0]      mul_signed,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  input  logic            flush,
  input  logic            out_ready,
  output logic            mul_ready,
  output logic            mul_doing,
  output logic            out_valid,
  output logic [XLEN-1:0] result_hi,
  output logic [XLEN-1:0] result_lo
);

  localparam int  EW  = XLEN + 2;
  localparam int  AW  = 2 * XLEN + 2;
  localparam int  CW  = $clog2(XLEN / 2 + 1);
  localparam bit  WEN = MULW_EN && (XLEN == 64);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [AW-1:0]  r_mcand;
  logic [EW:0]    r_mplier;
  logic [AW-1:0]  r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_wmode;

  logic           w_wmode;
  logic [EW-1:0]  w_ext_mc;
  logic [EW-1:0]  w_ext_mp;
  logic [AW-1:0]  w_pp;
  logic [AW-1:0]  w_acc_nx;
  logic [EW-2:0]  w_rest;
  logic           w_early;
  logic [CW-1:0]  w_last_cnt;
  logic           w_last;
  logic [XLEN-1:0] w_wlo;

  assign w_wmode = WEN && mulw;

  always_comb begin
    w_ext_mc = '0;
    w_ext_mp = '0;
    if (w_wmode) begin
      w_ext_mc = EW'($signed(multiplicand[31:0]));
      w_ext_mp = EW'($signed(multiplier[31:0]));
    end else begin
      w_ext_mc = {{2{mul_signed[1] & multiplicand[XLEN-1]}},
                  multiplicand};
      w_ext_mp = {{2{mul_signed[0] & multiplier[XLEN-1]}},
                  multiplier};
    end
  end

  // Booth triplet {m[2k+1], m[2k], m[2k-1]} sits in r_mplier[2:0]
  always_comb begin
    w_pp = '0;
    unique case (r_mplier[2:0])
      3'b001, 3'b010: w_pp = r_mcand;
      3'b011:         w_pp = r_mcand << 1;
      3'b100:         w_pp = -(r_mcand << 1);
      3'b101, 3'b110: w_pp = -r_mcand;
      default:        w_pp = '0;
    endcase
  end

  assign w_acc_nx   = r_acc + w_pp;
  assign w_rest     = r_mplier[EW:2];
  assign w_early    = (&w_rest) | ~(|w_rest);
  assign w_last_cnt = r_wmode ? CW'(16) : CW'(XLEN / 2);
  assign w_last     = (r_cnt == w_last_cnt) || w_early;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_wmode  <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (mul_valid) begin
            r_mcand  <= {{(AW-EW){w_ext_mc[EW-1]}}, w_ext_mc};
            r_mplier <= {w_ext_mp, 1'b0};
            r_acc    <= '0;
            r_cnt    <= '0;
            r_wmode  <= w_wmode;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_nx;
          r_mcand  <= r_mcand << 2;
          r_mplier <= {{2{r_mplier[EW]}}, r_mplier[EW:2]};
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_wlo = XLEN'($signed(r_acc[31:0]));

  assign mul_ready = (r_state == S_IDLE) && !flush && !reset;
  assign mul_doing = (r_state == S_BUSY);
  assign out_valid = (r_state == S_DONE);

  assign result_hi = (out_valid && !r_wmode) ?
                     r_acc[2*XLEN-1:XLEN] : '0;
  assign result_lo = !out_valid ? '0 :
                     r_wmode ? w_wlo : r_acc[XLEN-1:0];

endmodule

// File: doc/ysyx_22050854_multiplier_v2.md
YSYX_22050854_MULTIPLIER_V2 -- requirements
Module: ysyx_22050854_multiplier_v2

Interface
REQ-001 Parameter XLEN, default 64, operand width; legal values are 32 and 64.
REQ-002 Parameter MULW_EN, default 1, enables 32-bit word mode; it SHALL be legal only when XLEN=64.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mul_valid  input  1  request valid.
REQ-006 mulw  input  1  word mode; ignored when MULW_EN=0.
REQ-007 mul_signed  input  2  bit1=multiplicand signed, bit0=multiplier signed.
REQ-008 multiplicand  input  XLEN  first operand.
REQ-009 multiplier  input  XLEN  second operand.
REQ-010 flush  input  1  abort any operation in progress.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 mul_ready  output  1  block can accept a request.
REQ-013 mul_doing  output  1  iteration in progress.
REQ-014 out_valid  output  1  result valid, held until accepted.
REQ-015 result_hi  output  XLEN  upper half of product.
REQ-016 result_lo  output  XLEN  lower half of product.

Function
REQ-017 The block SHALL be a FSM with states IDLE, BUSY, DONE, using iterative radix-4 Booth recoding at one digit per BUSY cycle.
REQ-018 mul_ready SHALL be 1 exactly in IDLE with flush=0; mul_doing SHALL be 1 exactly in BUSY; out_valid SHALL be 1 exactly in DONE.
REQ-019 On mul_valid&mul_ready at a rising edge, the block SHALL latch operands, set the digit counter to 0, and enter BUSY.
REQ-020 Operands SHALL be extended to XLEN+2 bits by sign-extension if the corresponding mul_signed bit is 1, else zero-extension; all four mul_signed encodings are legal.
REQ-021 In word mode, operands SHALL be multiplicand[31:0] and multiplier[31:0], both signed; mul_signed and the upper 32 bits SHALL be ignored.
REQ-022 Each BUSY cycle SHALL add 0, ±M, or ±2M (M = extended multiplicand, shifted 2 bits per digit) into a 2*XLEN+2-bit accumulator, selected by the Booth triplet {m[2k+1], m[2k], m[2k-1]} with m[-1]=0.
REQ-023 BUSY SHALL exit to DONE after the digit where either the counter reaches the last digit, or all remaining unprocessed multiplier bits including the next m[2k+1] are all 0 or all 1 (early termination).
REQ-024 Digit count K SHALL be ≥1; worst case SHALL be XLEN/2+1 (33 for XLEN=64, 17 in word mode); out_valid SHALL rise K edges after the accepting edge.
REQ-025 In full mode, {result_hi,result_lo} SHALL equal the low 2*XLEN bits of the exact product.
REQ-026 In word mode, result_lo SHALL be sign-extended product[31:0], and result_hi SHALL be 0.
REQ-027 In DONE, the results SHALL stay stable while out_ready=0, and the block SHALL return to IDLE on the edge where out_ready=1.
REQ-028 result_hi and result_lo SHALL be 0 whenever out_valid=0.
REQ-029 flush=1 at an edge SHALL force IDLE from any state, discarding any result; with mul_valid=1 in the same cycle, flush SHALL win and no request SHALL be accepted.
REQ-030 mul_valid while not in IDLE SHALL be ignored; the request is not queued.

Reset
REQ-031 reset=1 SHALL immediately, without a clock edge, force IDLE and clear the counter, accumulator and operand registers.
REQ-032 During reset, the outputs SHALL be mul_ready=0, mul_doing=0, out_valid=0, result_hi=0, result_lo=0.
REQ-033 On the first edge after reset deasserts, mul_ready SHALL be 1, provided flush=0.
REQ-034 Reset asserted mid-BUSY or in DONE SHALL abandon the operation, and no out_valid SHALL follow.

Verification
REQ-035 XLEN=64, mul_signed=11, -3 × 7 -> result_hi=0xFFFFFFFFFFFFFFFF, result_lo=0xFFFFFFFFFFFFFFEB.
REQ-036 mul_signed=00, all-ones × all-ones -> hi=0xFFFFFFFFFFFFFFFE, lo=0x1, with K=33 (worst case); the same operands with mul_signed=10 -> hi=0xFFFFFFFFFFFFFFFF, lo=0x1.
REQ-037 mulw=1, 0xDEADBEEF40000000 × 0x1234567800000002 -> result_lo=0xFFFFFFFF80000000, result_hi=0.
REQ-038 Multiplier 0 or 1, any multiplicand -> out_valid one edge after accept, with the correct product.
REQ-039 out_ready held 0 for 5 cycles in DONE -> out_valid and results stable and mul_ready=0; out_ready=1 -> IDLE next edge; back-to-back requests give correct independent results.
REQ-040 flush at BUSY cycle 3 -> IDLE next edge with no out_valid; async reset mid-BUSY -> outputs zero before the next edge.
